xadc_drp_temp_sampler: RTL
==========================

// Module: xadc_drp_temp_sampler
// PURPOSE
//  Upstream stage of the XADC temperature monitor. On a start pulse it runs DRP reads of the
//  XADC temperature status register, averages 2**AVG_LOG2 12-bit codes and returns a 6-bit
//  bucket index plus done/error flags on dtr_temp_o. The monitor maps the index to degrees C.
// PARAMETERS
//  TEMP_ADDR      7'h00  DRP address of the temperature status register
//  AVG_LOG2       2      log2 of samples averaged per request (0..4)
//  TIMEOUT_CYCLES 1024   max cycles from den_o to drdy_i before abort (>=2)
// PORTS
//  clk_i        in   1   system clock, also drives XADC dclk
//  reset_n_i    in   1   asynchronous active-low reset
//  start_i      in   1   request pulse; accepted only in IDLE
//  busy_i       in   1   XADC busy_out
//  daddr_o      out  7   DRP address
//  den_o        out  1   DRP enable, one-cycle pulse per read
//  dwe_o        out  1   DRP write enable, tied 0
//  di_o         out  16  DRP write data, tied 0
//  do_i         in   16  DRP read data; code = do_i[15:4]
//  drdy_i       in   1   DRP data ready
//  dtr_temp_o   out  8   [7] done pulse, [6] timeout flag, [5:0] bucket index
//  avg_code_o   out  12  last averaged raw code (debug/readback)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, all outputs 0, accumulator/counters cleared.
//   Reset asserted mid-read drops den_o immediately. Late drdy_i after release is ignored.
//  FSM: IDLE -> WAIT_BUSY -> ISSUE -> WAIT_DRDY -> (ISSUE | DONE) -> IDLE.
//   IDLE: start_i=1 -> clear accumulator, sample counter and timeout flag; go WAIT_BUSY.
//   WAIT_BUSY: stay while busy_i=1; else go ISSUE. busy_i is checked only before the first read.
//   ISSUE: den_o=1 and daddr_o=TEMP_ADDR for exactly one cycle; load timeout counter; go WAIT_DRDY.
//   WAIT_DRDY: drdy_i=1 -> acc += do_i[15:4], count++; go DONE if count==2**AVG_LOG2,
//    else ISSUE. Timeout counter reaches TIMEOUT_CYCLES-1 without drdy -> set error, go DONE.
//   DONE: one cycle.
//    Success: avg = acc[11+AVG_LOG2:AVG_LOG2] (truncating), avg_code_o<=avg,
//     dtr_temp_o[5:0]<=avg[11:6], [6]<=0.
//    Timeout: [5:0] and avg_code_o keep previous values, [6]<=1.
//    Both cases: [7]=1 for this cycle only.
//  dtr_temp_o[7] is a single-cycle pulse so a consumer waiting on bit 7 never sees a stale
//   done. [6:0] hold until the next DONE.
//  Latency (busy_i=0, drdy one cycle after den): start_i to done pulse = 2 + 2*2**AVG_LOG2 cycles.
//  start_i outside IDLE is ignored (no queueing). drdy_i outside WAIT_DRDY is ignored.
//  drdy_i and timeout in the same cycle: drdy wins.
//  Accumulator is 12+AVG_LOG2 bits and cannot overflow. Sample counter is AVG_LOG2+1 bits.
//  daddr_o is held at TEMP_ADDR at all times. dwe_o and di_o are constant 0.
// TESTING
//  1. AVG_LOG2=0, drdy 1 cycle after den, do_i=16'hA000 -> one den pulse; done pulse 4 cycles
//     after start; [5:0]=6'h28, [6]=0; avg_code_o=12'hA00.
//  2. AVG_LOG2=2, codes 12'h800/801/802/803 -> exactly 4 den pulses, avg_code_o=12'h801,
//     [5:0]=6'h20, single done pulse.
//  3. Never assert drdy, TIMEOUT_CYCLES=16 -> done pulse with [6]=1; [5:0] and avg_code_o
//     keep prior values; next good run clears [6].
//  4. busy_i high 10 cycles after start -> no den during busy; first den on the cycle after
//     busy_i falls.
//  5. start_i re-pulsed mid-average, plus stray drdy_i in IDLE -> no extra reads or accumulation,
//     and the result equals the undisturbed run.
//  6. reset_n_i low during WAIT_DRDY -> den_o and dtr_temp_o go 0 asynchronously; after release
//     the FSM is in IDLE and a fresh start completes normally.

Source files
------------

// File: rtl/xadc_drp_temp_sampler_if.sv
// -----------------------------------------------------------------------------
// xadc_drp_temp_sampler_if
// Purpose : Groups the XADC dynamic reconfiguration port (DRP) signals and the
//           XADC busy flag that the temperature sampler uses. The sampler acts
//           as DRP master; the XADC primitive (or a bench model) is the slave.
// Signals :
//   daddr_o [6:0]  master -> slave  DRP address
//   den_o          master -> slave  DRP enable, one-cycle pulse per read
//   dwe_o          master -> slave  DRP write enable (never asserted)
//   di_o   [15:0]  master -> slave  DRP write data (never used)
//   do_i   [15:0]  slave  -> master DRP read data, 12-bit code in [15:4]
//   drdy_i         slave  -> master DRP data ready
//   busy_i         slave  -> master XADC busy_out
// The _o/_i suffixes name direction as seen from the sampler.
// -----------------------------------------------------------------------------
interface xadc_drp_temp_sampler_if;
    logic [6:0]  daddr_o;
    logic        den_o;
    logic        dwe_o;
    logic [15:0] di_o;
    logic [15:0] do_i;
    logic        drdy_i;
    logic        busy_i;

    modport master (
        output daddr_o,
        output den_o,
        output dwe_o,
        output di_o,
        input  do_i,
        input  drdy_i,
        input  busy_i
    );

    modport slave (
        input  daddr_o,
        input  den_o,
        input  dwe_o,
        input  di_o,
        output do_i,
        output drdy_i,
        output busy_i
    );
endinterface

// File: rtl/xadc_drp_temp_sampler.sv
// -----------------------------------------------------------------------------
// xadc_drp_temp_sampler
// Purpose : Upstream stage of the XADC temperature monitor. A start pulse
//           launches 2**AVG_LOG2 DRP reads of the temperature status register,
//           the 12-bit codes are summed and averaged (truncating), and the
//           result is published as a 6-bit bucket index with done/timeout
//           flags on dtr_temp_o. The full averaged code is kept on avg_code_o.
// Parameters:
//   TEMP_ADDR      DRP address of the temperature status register
//   AVG_LOG2       log2 of the number of samples averaged (0..4)
//   TIMEOUT_CYCLES max cycles waited for drdy after a read before aborting (>=2)
// Ports   :
//   clk_i       system clock (also the XADC dclk)
//   reset_n_i   asynchronous active-low reset
//   start_i     request pulse, accepted only while idle
//   drp         DRP master port plus XADC busy (see xadc_drp_temp_sampler_if)
//   dtr_temp_o  [7] done pulse, [6] timeout flag, [5:0] bucket index
//   avg_code_o  last successfully averaged 12-bit code
// -----------------------------------------------------------------------------
module xadc_drp_temp_sampler #(
    parameter logic [6:0] TEMP_ADDR      = 7'h00,
    parameter int         AVG_LOG2       = 2,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           start_i,
    xadc_drp_temp_sampler_if.master        drp,
    output logic [7:0]                     dtr_temp_o,
    output logic [11:0]                    avg_code_o
);

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale codes, so it
    // never wraps. The sample counter must be able to hold 2**AVG_LOG2 itself.
    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] NUM_SAMPLES = CNT_W'(32'd1 << AVG_LOG2);
    localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_BUSY = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_DRDY = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t             state_r;
    logic [ACC_W-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               den_r;
    logic [7:0]         dtr_r;
    logic [11:0]        avg_r;

    logic [11:0]        code_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [11:0]        avg_s;
    logic               unused_do_low_s;

    // The XADC left-justifies its 12-bit code; the low nibble carries nothing.
    assign code_s          = drp.do_i[15:4];
    assign unused_do_low_s = ^drp.do_i[3:0];

    // Running sum including the sample being returned this cycle, so the
    // final average can be registered on the same edge that ends the read.
    assign acc_sum_s = acc_r + ACC_W'(code_s);
    assign cnt_inc_s = cnt_r + CNT_W'(1'b1);
    assign avg_s     = acc_sum_s[11+AVG_LOG2:AVG_LOG2];

    // The sampler only ever reads one fixed register.
    assign drp.daddr_o = TEMP_ADDR;
    assign drp.dwe_o   = 1'b0;
    assign drp.di_o    = 16'h0000;

    assign drp.den_o   = den_r;
    assign dtr_temp_o  = dtr_r;
    assign avg_code_o  = avg_r;

    // Request sequencer: busy gate, per-sample read/response, timeout and
    // publication of the result. All outputs are registered here.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_IDLE;
            acc_r   <= '0;
            cnt_r   <= '0;
            tmo_r   <= '0;
            den_r   <= 1'b0;
            dtr_r   <= 8'h00;
            avg_r   <= 12'h000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    den_r <= 1'b0;
                    if (start_i) begin
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        tmo_r   <= '0;
                        state_r <= ST_WAIT_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                // busy_i is honoured only before the first read; later
                // samples in the same request go straight to ISSUE.
                ST_WAIT_BUSY: begin
                    if (drp.busy_i) begin
                        state_r <= ST_WAIT_BUSY;
                    end else begin
                        den_r   <= 1'b1;
                        state_r <= ST_ISSUE;
                    end
                end

                // den_r was raised on entry, so it is high for exactly the
                // one cycle spent here.
                ST_ISSUE: begin
                    den_r   <= 1'b0;
                    tmo_r   <= '0;
                    state_r <= ST_WAIT_DRDY;
                end

                // drdy is checked before the timeout so a response on the
                // last permitted cycle is still accepted.
                ST_WAIT_DRDY: begin
                    if (drp.drdy_i) begin
                        acc_r <= acc_sum_s;
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == NUM_SAMPLES) begin
                            avg_r   <= avg_s;
                            dtr_r   <= {1'b1, 1'b0, avg_s[11:6]};
                            state_r <= ST_DONE;
                        end else begin
                            den_r   <= 1'b1;
                            state_r <= ST_ISSUE;
                        end
                    end else if (tmo_r == TMO_LAST) begin
                        // Abort: bucket and avg_code keep the last good result.
                        dtr_r[7] <= 1'b1;
                        dtr_r[6] <= 1'b1;
                        state_r  <= ST_DONE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1'b1);
                    end
                end

                // Done is a one-cycle pulse; [6:0] hold until the next result.
                ST_DONE: begin
                    dtr_r[7] <= 1'b0;
                    state_r  <= ST_IDLE;
                end

                default: begin
                    den_r   <= 1'b0;
                    dtr_r   <= 8'h00;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
